// File: rtl/rx_hp_pkg.sv
// Shared definitions for the huge-page address snoop: TLP fmt/type codes,
// parser state encoding and the DW byte-swap helper.
package rx_hp_pkg;

    localparam logic [6:0] MWR32_FMT_TYPE = 7'b10_00000;
    localparam logic [6:0] MWR64_FMT_TYPE = 7'b11_00000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR1  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_e;

    // TRN payload arrives in wire (big-endian) byte order; registers hold host order.
    function automatic logic [31:0] dw_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/rx_hp_regfile.sv
// Huge-page address and status registers: half-word address writes, unlock
// handling with priority over free, and the unlock overrun pulse.
module rx_hp_regfile
    import rx_hp_pkg::*;
#(
    parameter int NUM_PAGES = 2,
    parameter int PIDX_W    = 1
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    addrWe_i,
    input  logic [PIDX_W-1:0]       addrPage_i,
    input  logic                    loEn_i,
    input  logic                    hiEn_i,
    input  logic [31:0]             loData_i,
    input  logic [31:0]             hiData_i,
    input  logic                    unlockWe_i,
    input  logic [PIDX_W-1:0]       unlockPage_i,
    input  logic [NUM_PAGES-1:0]    free_i,
    output logic [64*NUM_PAGES-1:0] addr_o,
    output logic [NUM_PAGES-1:0]    status_o,
    output logic [NUM_PAGES-1:0]    overrun_o
);

    logic [64*NUM_PAGES-1:0] addr_q, addr_d;
    logic [NUM_PAGES-1:0]    status_q, status_d;
    logic [NUM_PAGES-1:0]    overrun_q, overrun_d;

    // Free is applied first so that an unlock on the same edge overrides it.
    always_comb begin
        addr_d    = addr_q;
        status_d  = status_q & ~free_i;
        overrun_d = '0;
        for (int i = 0; i < NUM_PAGES; i++) begin
            if (addrWe_i && addrPage_i == PIDX_W'(i)) begin
                if (loEn_i) addr_d[64*i +: 32]    = loData_i;
                if (hiEn_i) addr_d[64*i+32 +: 32] = hiData_i;
            end
            if (unlockWe_i && unlockPage_i == PIDX_W'(i)) begin
                status_d[i]  = 1'b1;
                overrun_d[i] = status_q[i];
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q    <= '0;
            status_q  <= '0;
            overrun_q <= '0;
        end else begin
            addr_q    <= addr_d;
            status_q  <= status_d;
            overrun_q <= overrun_d;
        end
    end

    assign addr_o    = addr_q;
    assign status_o  = status_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/rx_huge_pages_addr_mc.sv
// Passive TRN RX snoop: parses MWr32/MWr64 TLPs hitting one BAR and commits
// huge-page addresses and unlocks at a clean TLP end.
module rx_huge_pages_addr_mc
    import rx_hp_pkg::*;
#(
    parameter int NUM_PAGES      = 2,
    parameter int BAR_IDX        = 2,
    parameter int ADDR_BASE_DW   = 16,
    parameter int UNLOCK_BASE_DW = 24
) (
    input  logic                    trn_clk,
    input  logic                    reset,
    input  logic [63:0]             trn_rd,
    input  logic [7:0]              trn_rrem_n,
    input  logic                    trn_rsof_n,
    input  logic                    trn_reof_n,
    input  logic                    trn_rsrc_rdy_n,
    input  logic                    trn_rsrc_dsc_n,
    input  logic [6:0]              trn_rbar_hit_n,
    input  logic                    trn_rdst_rdy_n,
    output logic [64*NUM_PAGES-1:0] huge_page_addr,
    output logic [NUM_PAGES-1:0]    huge_page_status,
    input  logic [NUM_PAGES-1:0]    huge_page_free,
    output logic [NUM_PAGES-1:0]    unlock_overrun
);

    localparam int PIDX_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam logic [6:0] ADDR_LO    = 7'(ADDR_BASE_DW);
    localparam logic [6:0] ADDR_END   = 7'(ADDR_BASE_DW + 2 * NUM_PAGES);
    localparam logic [6:0] UNLOCK_LO  = 7'(UNLOCK_BASE_DW);
    localparam logic [6:0] UNLOCK_END = 7'(UNLOCK_BASE_DW + NUM_PAGES);

    rx_state_e   state_q, state_d;
    logic        is64_q, is64_d;
    logic [9:0]  len_q, len_d;
    logic [3:0]  fbe_q, fbe_d;
    logic [3:0]  lbe_q, lbe_d;
    logic [5:0]  offset_q, offset_d;
    logic [31:0] data0_q, data0_d;

    logic        beat, sof, eof, barHit, isMwr;
    logic [5:0]  hdrOffset;
    logic        atEnd, lenOne, lenTwo, shapeOk, commit;
    logic [5:0]  commitOffset;
    logic [31:0] commitD0, commitD1;
    logic [6:0]  off7, addrRel, unlockRel;
    logic        inAddr, inUnlock, addrHi;
    logic        addrWe, loEn, hiEn, unlockWe;
    logic [31:0] loData, hiData;
    logic        unusedBits;

    assign beat      = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    assign sof       = beat && !trn_rsof_n;
    assign eof       = beat && !trn_reof_n;
    assign barHit    = !trn_rbar_hit_n[BAR_IDX];
    assign isMwr     = (trn_rd[62:56] == MWR32_FMT_TYPE) || (trn_rd[62:56] == MWR64_FMT_TYPE);
    assign hdrOffset = is64_q ? trn_rd[7:2] : trn_rd[39:34];

    // A sof+eof beat is a header-only TLP: never a write we accept, so stay idle.
    always_comb begin
        state_d  = state_q;
        is64_d   = is64_q;
        len_d    = len_q;
        fbe_d    = fbe_q;
        lbe_d    = lbe_q;
        offset_d = offset_q;
        data0_d  = data0_q;
        case (state_q)
            ST_IDLE: begin
                if (sof) begin
                    is64_d = trn_rd[61];
                    len_d  = trn_rd[41:32];
                    fbe_d  = trn_rd[3:0];
                    lbe_d  = trn_rd[7:4];
                    if (!eof) state_d = (barHit && isMwr) ? ST_HDR1 : ST_DRAIN;
                end
            end
            ST_HDR1: begin
                if (beat) begin
                    offset_d = hdrOffset;
                    data0_d  = dw_swap(trn_rd[31:0]);
                    state_d  = eof ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) state_d = eof ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (eof) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            is64_q   <= 1'b0;
            len_q    <= '0;
            fbe_q    <= '0;
            lbe_q    <= '0;
            offset_q <= '0;
            data0_q  <= '0;
        end else begin
            state_q  <= state_d;
            is64_q   <= is64_d;
            len_q    <= len_d;
            fbe_q    <= fbe_d;
            lbe_q    <= lbe_d;
            offset_q <= offset_d;
            data0_q  <= data0_d;
        end
    end

    // The eof beat only counts when it lands in the phase the length implies.
    always_comb begin
        atEnd        = 1'b0;
        commitOffset = offset_q;
        commitD0     = is64_q ? dw_swap(trn_rd[63:32]) : data0_q;
        commitD1     = is64_q ? dw_swap(trn_rd[31:0]) : dw_swap(trn_rd[63:32]);
        if (state_q == ST_HDR1) begin
            atEnd        = eof && !is64_q && (len_q == 10'd1);
            commitOffset = hdrOffset;
            commitD0     = dw_swap(trn_rd[31:0]);
        end else if (state_q == ST_DATA) begin
            atEnd = eof && (is64_q || len_q == 10'd2);
        end
    end

    assign lenOne  = (len_q == 10'd1);
    assign lenTwo  = (len_q == 10'd2);
    assign shapeOk = (lenOne && fbe_q == 4'hF && lbe_q == 4'h0) ||
                     (lenTwo && fbe_q == 4'hF && lbe_q == 4'hF);
    assign commit  = atEnd && trn_rsrc_dsc_n && shapeOk;

    assign off7      = {1'b0, commitOffset};
    assign addrRel   = off7 - ADDR_LO;
    assign unlockRel = off7 - UNLOCK_LO;
    assign inAddr    = (off7 >= ADDR_LO) && (off7 < ADDR_END);
    assign inUnlock  = (off7 >= UNLOCK_LO) && (off7 < UNLOCK_END);
    assign addrHi    = addrRel[0];

    // Two-DW writes must start at a lo DW so both halves land in one page.
    assign addrWe   = commit && inAddr && (lenOne || !addrHi);
    assign loEn     = !addrHi;
    assign hiEn     = addrHi || lenTwo;
    assign loData   = commitD0;
    assign hiData   = lenTwo ? commitD1 : commitD0;
    assign unlockWe = commit && inUnlock && lenOne;

    rx_hp_regfile #(
        .NUM_PAGES (NUM_PAGES),
        .PIDX_W    (PIDX_W)
    ) u_regfile (
        .clock_i      (trn_clk),
        .reset_i      (reset),
        .addrWe_i     (addrWe),
        .addrPage_i   (addrRel[PIDX_W:1]),
        .loEn_i       (loEn),
        .hiEn_i       (hiEn),
        .loData_i     (loData),
        .hiData_i     (hiData),
        .unlockWe_i   (unlockWe),
        .unlockPage_i (unlockRel[PIDX_W-1:0]),
        .free_i       (huge_page_free),
        .addr_o       (huge_page_addr),
        .status_o     (huge_page_status),
        .overrun_o    (unlock_overrun)
    );

    assign unusedBits = ^{trn_rrem_n, trn_rd, trn_rbar_hit_n, addrRel, unlockRel};

endmodule

// File: tb/tb_rx_huge_pages_addr_mc.sv
// Directed bench for rx_huge_pages_addr_mc: table of whole-TLP vectors plus
// hand sequences for unlock/free, early eof and mid-TLP reset.
module tb_rx_huge_pages_addr_mc;
    import rx_hp_pkg::*;

    localparam int NUM_PAGES = 2;
    localparam int BAR_IDX   = 2;
    localparam logic [6:0] FT_MWR32 = 7'b10_00000;
    localparam logic [6:0] FT_MWR64 = 7'b11_00000;
    localparam logic [6:0] FT_MRD32 = 7'b00_00000;
    localparam logic [6:0] BAR_OK_N  = 7'b111_1011;
    localparam logic [6:0] BAR_BAD_N = 7'b111_1110;

    logic                    trn_clk = 1'b0;
    logic                    reset;
    logic [63:0]             trn_rd;
    logic [7:0]              trn_rrem_n;
    logic                    trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n;
    logic [6:0]              trn_rbar_hit_n;
    logic [64*NUM_PAGES-1:0] huge_page_addr;
    logic [NUM_PAGES-1:0]    huge_page_status, huge_page_free, unlock_overrun;

    int checks = 0;
    int errors = 0;
    logic [63:0] beatBuf [8];
    int          beatCnt;
    logic [1:0]  freeOnEof = 2'b00;

    typedef struct {
        string       name;
        logic [6:0]  ft;
        logic        barOk;
        logic [9:0]  len;
        logic [3:0]  fbe;
        logic [3:0]  lbe;
        logic [5:0]  off;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        dsc;
        logic        stall;
        logic [127:0] expAddr;
        logic [1:0]  expStatus;
    } vec_t;
    vec_t vecs[$];

    rx_huge_pages_addr_mc #(
        .NUM_PAGES(NUM_PAGES), .BAR_IDX(BAR_IDX), .ADDR_BASE_DW(16), .UNLOCK_BASE_DW(24)
    ) dut (
        .trn_clk          (trn_clk),
        .reset            (reset),
        .trn_rd           (trn_rd),
        .trn_rrem_n       (trn_rrem_n),
        .trn_rsof_n       (trn_rsof_n),
        .trn_reof_n       (trn_reof_n),
        .trn_rsrc_rdy_n   (trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n   (trn_rsrc_dsc_n),
        .trn_rbar_hit_n   (trn_rbar_hit_n),
        .trn_rdst_rdy_n   (trn_rdst_rdy_n),
        .huge_page_addr   (huge_page_addr),
        .huge_page_status (huge_page_status),
        .huge_page_free   (huge_page_free),
        .unlock_overrun   (unlock_overrun)
    );

    always #5 trn_clk = ~trn_clk;

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idleBus();
        trn_rsrc_rdy_n = 1'b1;
        trn_rdst_rdy_n = 1'b0;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_rd         = '0;
        trn_rrem_n     = 8'h00;
    endtask

    // Wire format: DW0 in [63:32] of the first beat, payload DWs packed after the header.
    task automatic buildTlp(input logic [6:0] ft, input logic [9:0] len, input logic [3:0] fbe,
                            input logic [3:0] lbe, input logic [5:0] off,
                            input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] dws [12];
        logic [31:0] addr32;
        int nd, nh, total;
        for (int k = 0; k < 12; k++) dws[k] = 32'h0;
        addr32 = 32'hF000_0000 | {24'h0, off, 2'b00};
        nd = ft[6] ? int'(len) : 0;
        if (nd > 8) nd = 8;
        nh = ft[5] ? 4 : 3;
        dws[0] = {1'b0, ft, 8'h00, 6'h00, len};
        dws[1] = {16'h0100, 8'h00, lbe, fbe};
        if (nh == 4) begin
            dws[2] = 32'h0000_0001;
            dws[3] = addr32;
        end else begin
            dws[2] = addr32;
        end
        for (int k = 0; k < nd; k++) dws[nh+k] = (k == 0) ? d0 : (k == 1) ? d1 : 32'h0;
        total   = nh + nd;
        beatCnt = (total + 1) / 2;
        for (int b = 0; b < beatCnt; b++) beatBuf[b] = {dws[2*b], dws[2*b+1]};
    endtask

    task automatic driveBeat(input int b, input logic last, input logic dsc,
                             input logic barOk, input logic stall);
        if (stall) begin
            trn_rd         = {$urandom, $urandom};
            trn_rsof_n     = 1'($urandom_range(0, 1));
            trn_reof_n     = 1'($urandom_range(0, 1));
            trn_rsrc_dsc_n = 1'b1;
            trn_rsrc_rdy_n = (b % 2 == 0);
            trn_rdst_rdy_n = (b % 2 != 0);
            @(posedge trn_clk); #1;
        end
        trn_rd         = beatBuf[b];
        trn_rrem_n     = 8'h00;
        trn_rsof_n     = (b != 0);
        trn_reof_n     = !last;
        trn_rsrc_dsc_n = !(last && dsc);
        trn_rsrc_rdy_n = 1'b0;
        trn_rdst_rdy_n = 1'b0;
        trn_rbar_hit_n = barOk ? BAR_OK_N : BAR_BAD_N;
        huge_page_free = last ? freeOnEof : 2'b00;
        @(posedge trn_clk); #1;
    endtask

    task automatic sendTlp(input logic [6:0] ft, input logic barOk, input logic [9:0] len,
                           input logic [3:0] fbe, input logic [3:0] lbe, input logic [5:0] off,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic dsc, input logic stall);
        buildTlp(ft, len, fbe, lbe, off, d0, d1);
        for (int b = 0; b < beatCnt; b++) driveBeat(b, b == beatCnt - 1, dsc, barOk, stall);
        idleBus();
    endtask

    task automatic addVec(input string name, input logic [6:0] ft, input logic barOk,
                          input logic [9:0] len, input logic [3:0] fbe, input logic [3:0] lbe,
                          input logic [5:0] off, input logic [31:0] d0, input logic [31:0] d1,
                          input logic dsc, input logic stall,
                          input logic [127:0] expAddr, input logic [1:0] expStatus);
        vec_t v;
        v.name = name; v.ft = ft; v.barOk = barOk; v.len = len; v.fbe = fbe; v.lbe = lbe;
        v.off = off; v.d0 = d0; v.d1 = d1; v.dsc = dsc; v.stall = stall;
        v.expAddr = expAddr; v.expStatus = expStatus;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus();
        foreach (vecs[i]) begin
            sendTlp(vecs[i].ft, vecs[i].barOk, vecs[i].len, vecs[i].fbe, vecs[i].lbe, vecs[i].off,
                    vecs[i].d0, vecs[i].d1, vecs[i].dsc, vecs[i].stall);
            checkOutput({vecs[i].name, "_addr"}, huge_page_addr, vecs[i].expAddr);
            checkOutput({vecs[i].name, "_status"}, {126'h0, huge_page_status}, {126'h0, vecs[i].expStatus});
        end
    endtask

    localparam logic [127:0] A1  = {64'h0, 64'h9ABCDEF0_12345678};
    localparam logic [127:0] A2  = {64'h55667788_11223344, 64'h9ABCDEF0_12345678};
    localparam logic [127:0] A3  = {64'h0A0B0C0D_11223344, 64'h9ABCDEF0_12345678};
    localparam logic [127:0] A4  = {64'h0A0B0C0D_11223344, 64'h9ABCDEF0_DEADBEEF};
    localparam logic [127:0] A5  = {64'h0A0B0C0D_11223344, 64'h01020304_DEADBEEF};
    localparam logic [127:0] A6  = {64'h0A0B0C0D_11223344, 64'h9ABCDEF0_01234567};
    localparam logic [127:0] A7  = {64'h9ABCDEF0_12345678, 64'h0};

    initial begin
        reset = 1'b1;
        huge_page_free = 2'b00;
        trn_rbar_hit_n = BAR_OK_N;
        idleBus();
        repeat (3) @(posedge trn_clk);
        #1;
        checkOutput("reset_addr", huge_page_addr, '0);
        checkOutput("reset_status", {126'h0, huge_page_status}, '0);
        checkOutput("reset_overrun", {126'h0, unlock_overrun}, '0);
        reset = 1'b0;
        @(posedge trn_clk); #1;

        addVec("mwr32_len2_off16", FT_MWR32, 1, 2, 4'hF, 4'hF, 16, 32'h78563412, 32'hF0DEBC9A, 0, 0, A1, 2'b00);
        addVec("mwr64_len2_off18", FT_MWR64, 1, 2, 4'hF, 4'hF, 18, 32'h44332211, 32'h88776655, 0, 0, A2, 2'b00);
        addVec("mwr64_discontinue", FT_MWR64, 1, 2, 4'hF, 4'hF, 18, 32'hAAAAAAAA, 32'hBBBBBBBB, 1, 0, A2, 2'b00);
        addVec("rej_fbe7", FT_MWR32, 1, 1, 4'h7, 4'h0, 16, 32'h11111111, 32'h0, 0, 0, A2, 2'b00);
        addVec("rej_bar", FT_MWR32, 0, 1, 4'hF, 4'h0, 17, 32'h22222222, 32'h0, 0, 0, A2, 2'b00);
        addVec("rej_len2_hi", FT_MWR32, 1, 2, 4'hF, 4'hF, 17, 32'h33333333, 32'h44444444, 0, 0, A2, 2'b00);
        addVec("rej_mrd32", FT_MRD32, 1, 1, 4'hF, 4'h0, 16, 32'h0, 32'h0, 0, 0, A2, 2'b00);
        addVec("rej_len8", FT_MWR32, 1, 8, 4'hF, 4'hF, 16, 32'h55555555, 32'h66666666, 0, 0, A2, 2'b00);
        addVec("rej_len2_unlock", FT_MWR32, 1, 2, 4'hF, 4'hF, 24, 32'h1, 32'h2, 0, 0, A2, 2'b00);
        addVec("rej_gap_off20", FT_MWR32, 1, 1, 4'hF, 4'h0, 20, 32'h77777777, 32'h0, 0, 0, A2, 2'b00);
        addVec("len1_hi_page1", FT_MWR32, 1, 1, 4'hF, 4'h0, 19, 32'h0D0C0B0A, 32'h0, 0, 0, A3, 2'b00);
        addVec("mwr64_len1_lo_page0", FT_MWR64, 1, 1, 4'hF, 4'h0, 16, 32'hEFBEADDE, 32'h0, 0, 0, A4, 2'b00);
        addVec("len1_hi_page0", FT_MWR32, 1, 1, 4'hF, 4'h0, 17, 32'h04030201, 32'h0, 0, 0, A5, 2'b00);
        addVec("stalled_case1", FT_MWR32, 1, 2, 4'hF, 4'hF, 16, 32'h78563412, 32'hF0DEBC9A, 0, 1, A3, 2'b00);
        addVec("unlock_page0", FT_MWR32, 1, 1, 4'hF, 4'h0, 24, 32'hDEADBEEF, 32'h0, 0, 0, A3, 2'b01);
        applyStimulus();

        // Unlock, overrun and unlock-versus-free on page 1
        sendTlp(FT_MWR32, 1, 1, 4'hF, 4'h0, 25, 32'h0, 32'h0, 0, 0);
        checkOutput("unlock1_status", {126'h0, huge_page_status}, {126'h0, 2'b11});
        checkOutput("unlock1_overrun", {126'h0, unlock_overrun}, '0);
        sendTlp(FT_MWR32, 1, 1, 4'hF, 4'h0, 25, 32'h0, 32'h0, 0, 0);
        checkOutput("unlock2_overrun", {126'h0, unlock_overrun}, {126'h0, 2'b10});
        checkOutput("unlock2_status", {126'h0, huge_page_status}, {126'h0, 2'b11});
        @(posedge trn_clk); #1;
        checkOutput("overrun_pulse_end", {126'h0, unlock_overrun}, '0);
        freeOnEof = 2'b10;
        sendTlp(FT_MWR32, 1, 1, 4'hF, 4'h0, 25, 32'h0, 32'h0, 0, 0);
        freeOnEof = 2'b00;
        checkOutput("unlock_beats_free", {126'h0, huge_page_status}, {126'h0, 2'b11});
        @(posedge trn_clk); #1;
        huge_page_free = 2'b00;
        checkOutput("free_alone", {126'h0, huge_page_status}, {126'h0, 2'b01});

        // Early eof on a two-DW MWr32, then a back-to-back valid write
        buildTlp(FT_MWR32, 2, 4'hF, 4'hF, 16, 32'h99999999, 32'h88888888);
        driveBeat(0, 0, 0, 1, 0);
        driveBeat(1, 1, 0, 1, 0);
        checkOutput("early_eof_dropped", huge_page_addr, A3);
        sendTlp(FT_MWR32, 1, 1, 4'hF, 4'h0, 16, 32'h67452301, 32'h0, 0, 0);
        checkOutput("after_early_eof", huge_page_addr, A6);

        // Reset between HDR1 and DATA, then orphan continuation, then a full TLP
        buildTlp(FT_MWR32, 2, 4'hF, 4'hF, 16, 32'h11111111, 32'h22222222);
        driveBeat(0, 0, 0, 1, 0);
        driveBeat(1, 0, 0, 1, 0);
        reset = 1'b1;
        idleBus();
        #1;
        checkOutput("midtlp_reset_addr", huge_page_addr, '0);
        checkOutput("midtlp_reset_status", {126'h0, huge_page_status}, '0);
        @(posedge trn_clk); #1;
        reset = 1'b0;
        driveBeat(2, 1, 0, 1, 0);
        idleBus();
        @(posedge trn_clk); #1;
        checkOutput("orphan_beat_ignored", huge_page_addr, '0);
        buildTlp(FT_MWR32, 2, 4'hF, 4'hF, 18, 32'h78563412, 32'hF0DEBC9A);
        driveBeat(0, 0, 0, 1, 0);
        driveBeat(1, 0, 0, 1, 0);
        checkOutput("no_commit_before_eof", huge_page_addr, '0);
        driveBeat(2, 1, 0, 1, 0);
        idleBus();
        checkOutput("post_reset_commit", huge_page_addr, A7);
        checkOutput("post_reset_status", {126'h0, huge_page_status}, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
